sync_frame_tx: RTL and testbench

//  Transmit end of the serial "1001" sequence-detect link. Accepts a parallel

---
 rtl/sync_frame_tx.sv | 138 +++++++++++++
 tb/tb_sync_frame_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_frame_tx.sv
// rtl/sync_frame_tx.sv - serial frame transmitter: SYNC pattern, payload, guard bit
//
// Shifts one frame out on a single registered data line, one bit per clock:
// SYNC (MSB first), then the captured payload (MSB first), then one guard 0.
// The line idles at 0.
//
// Ports
//   clk      in   1      clock, all logic on the rising edge
//   rst      in   1      synchronous reset, active-high
//   valid    in   1      payload offered this cycle
//   payload  in   WIDTH  word to send, sampled only on acceptance
//   ready    out  1      transmitter idle, can accept a word
//   data     out  1      serial line
//   busy     out  1      frame in progress (SYNC, PAYLOAD or GUARD)
//   done     out  1      one-cycle pulse during the guard bit
module sync_frame_tx #(
  parameter int                  WIDTH    = 8,
  parameter int                  SYNC_LEN = 4,
  parameter logic [SYNC_LEN-1:0] SYNC     = 4'b1001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] payload,
  output logic             ready,
  output logic             data,
  output logic             busy,
  output logic             done
);

  localparam int MAXLEN = (SYNC_LEN > WIDTH) ? SYNC_LEN : WIDTH;
  localparam int CW     = $clog2(MAXLEN + 1);
  localparam int SW     = SYNC_LEN + WIDTH;

  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_LEN - 1);
  localparam logic [CW-1:0] PAY_LAST  = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SYNC    = 2'd1,
    S_PAYLOAD = 2'd2,
    S_GUARD   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   shreg_q, shreg_d;
  logic            data_q, data_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Next-state logic works one cycle ahead: data_d is the bit that will be on
  // the line during the cycle state_d describes. SYNC and payload share one
  // shift register loaded with {SYNC, payload}; its MSB goes straight onto the
  // line at acceptance, so the register is stored already shifted by one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid) begin
          state_d = S_SYNC;
          cnt_d   = '0;
          shreg_d = {SYNC, payload} << 1;
          data_d  = SYNC[SYNC_LEN-1];
        end
      end

      S_SYNC: begin
        data_d  = shreg_q[SW-1];
        shreg_d = shreg_q << 1;
        if (cnt_q == SYNC_LAST) begin
          state_d = S_PAYLOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_PAYLOAD: begin
        if (cnt_q == PAY_LAST) begin
          state_d = S_GUARD;
          cnt_d   = '0;
          data_d  = 1'b0;
        end else begin
          data_d  = shreg_q[SW-1];
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + CW'(1);
        end
      end

      S_GUARD: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Status flags are registered copies of the next state's decode.
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_GUARD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign data  = data_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// tb/tb_sync_frame_tx.sv - directed scoreboard bench for sync_frame_tx
module tb_sync_frame_tx;

  localparam int WIDTH    = 8;
  localparam int SYNC_LEN = 4;
  localparam int FRAME    = SYNC_LEN + WIDTH + 1;

  logic             clk;
  logic             rst;
  logic             valid;
  logic [WIDTH-1:0] payload;
  logic             ready;
  logic             data;
  logic             busy;
  logic             done;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic   exp_q[$];
  logic [SYNC_LEN-1:0] sync_pat = 4'b1001;

  // Downstream 1001 Moore detector fed by the serial line.
  logic [2:0] det_st;
  logic       det_out;

  sync_frame_tx #(
    .WIDTH(WIDTH),
    .SYNC_LEN(SYNC_LEN),
    .SYNC(4'b1001)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid(valid),
    .payload(payload),
    .ready(ready),
    .data(data),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) det_st <= 3'd0;
    else begin
      case (det_st)
        3'd0:    det_st <= data ? 3'd1 : 3'd0;
        3'd1:    det_st <= data ? 3'd1 : 3'd2;
        3'd2:    det_st <= data ? 3'd1 : 3'd3;
        3'd3:    det_st <= data ? 3'd4 : 3'd0;
        3'd4:    det_st <= data ? 3'd1 : 3'd2;
        default: det_st <= 3'd0;
      endcase
    end
  end
  assign det_out = (det_st == 3'd4);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_frame(input logic [WIDTH-1:0] p);
    for (int i = SYNC_LEN - 1; i >= 0; i--) exp_q.push_back(sync_pat[i]);
    for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(p[i]);
    exp_q.push_back(1'b0);
  endtask

  // Waits (bounded) for ready, offers p, steps through the accepting edge.
  // valid is left high; the caller drops it when it wants.
  task automatic accept(input logic [WIDTH-1:0] p);
    int n;
    n = 0;
    while (!ready && n < 50) begin
      step();
      n++;
    end
    chk("ready_before_accept", 32'(ready), 32'd1);
    valid   = 1'b1;
    payload = p;
    step();
    push_frame(p);
  endtask

  // Compares one whole frame against the scoreboard, starting with the first
  // sync bit currently on the line, then the idle cycle after the guard bit.
  task automatic check_frame(input bit det_chk);
    logic b;
    for (int i = 0; i < FRAME; i++) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
        b = 1'b0;
      end else begin
        b = exp_q.pop_front();
      end
      chk($sformatf("data_bit%0d", i), 32'(data), 32'(b));
      chk($sformatf("busy_bit%0d", i), 32'(busy), 32'd1);
      chk($sformatf("ready_bit%0d", i), 32'(ready), 32'd0);
      chk($sformatf("done_bit%0d", i), 32'(done), (i == FRAME - 1) ? 32'd1 : 32'd0);
      if (det_chk && i == SYNC_LEN - 1) chk("det_before_4th", 32'(det_out), 32'd0);
      if (det_chk && i == SYNC_LEN)     chk("det_after_4th", 32'(det_out), 32'd1);
      if (i < FRAME - 1) step();
    end
    step();
    chk("ready_after_frame", 32'(ready), 32'd1);
    chk("busy_after_frame", 32'(busy), 32'd0);
    chk("done_after_frame", 32'(done), 32'd0);
    chk("data_after_frame", 32'(data), 32'd0);
  endtask

  initial begin
    int t_first;
    logic b;

    // 1: reset held two cycles with valid high
    rst     = 1'b1;
    valid   = 1'b1;
    payload = 8'hA5;
    step();
    step();
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst   = 1'b0;
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_data", 32'(data), 32'd0);
      chk("idle_ready", 32'(ready), 32'd1);
    end

    // 2: single frame A5
    accept(8'hA5);
    valid = 1'b0;
    check_frame(1'b0);

    // 3: back-to-back with valid held high; payload change while busy ignored
    accept(8'hFF);
    t_first = cyc;
    payload = 8'h00;
    check_frame(1'b0);
    accept(8'h00);
    chk("b2b_period", 32'(cyc - t_first), 32'd14);
    valid = 1'b0;
    check_frame(1'b0);

    // 4: reset during the 6th frame cycle truncates the frame
    accept(8'hC3);
    valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b = exp_q.pop_front();
      chk($sformatf("trunc_bit%0d", i), 32'(data), 32'(b));
      if (i < 5) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_data", 32'(data), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("postrst_done", 32'(done), 32'd0);
      chk("postrst_data", 32'(data), 32'd0);
    end
    accept(8'h3C);
    valid = 1'b0;
    check_frame(1'b0);

    // 5: loopback into the detector, both reset together
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("det_reset", 32'(det_out), 32'd0);
    accept(8'h00);
    valid = 1'b0;
    check_frame(1'b1);

    // 6: payload change the cycle after acceptance has no effect
    accept(8'h81);
    valid   = 1'b0;
    payload = 8'h7E;
    check_frame(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
